// File: rtl/edge_frame_sequencer.sv
// Frame-level sequencer ahead of the Sobel line-buffer/conv pipeline: gates the pixel
// stream, injects zero flush lines, counts results and pulses done. Optional macro: SEQ_TIMEOUT_EN.
module edge_frame_sequencer #(
  parameter int W_BITS         = 11,
  parameter int H_BITS         = 11,
  parameter int FLUSH_LINES    = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [W_BITS-1:0] i_width,
  input  logic [H_BITS-1:0] i_height,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              i_ds_full,
  output logic              o_pix_valid,
  output logic [7:0]        o_pix_data,
  input  logic              i_res_valid,
  output logic              o_busy,
  output logic              o_done_intr,
  output logic              o_err,
  output logic [2:0]        dbg_state
);

  localparam int CW = W_BITS + H_BITS;
  localparam logic [CW-1:0] ONE = CW'(1);

  // Handshake: an upstream beat transfers on a rising clock edge where s_valid && s_ready;
  // s_ready is combinational (RUN and no downstream backpressure) and never depends on s_valid.

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] frame_total;
  logic [CW-1:0] flush_total;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] res_cnt;
  logic          start_ok;
  logic          geom_zero;
  logic          accept;
  logic          flush_beat;
  logic          count_en;
  logic          timeout;

  assign start_ok   = (state == ST_IDLE) && i_start;
  assign geom_zero  = (i_width == '0) || (i_height == '0);
  assign s_ready    = (state == ST_RUN) && !i_ds_full;
  assign accept     = s_valid && s_ready;
  assign flush_beat = (state == ST_FLUSH) && !i_ds_full;
  assign count_en   = (state == ST_RUN) || (state == ST_FLUSH) || (state == ST_DRAIN);
  assign o_busy     = (state != ST_IDLE);
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = geom_zero ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (accept && (in_cnt == frame_total - ONE))
          state_nxt = (FLUSH_LINES == 0) ? ST_DRAIN : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_beat && (flush_cnt == flush_total - ONE)) state_nxt = ST_DRAIN;
      end
      // DRAIN looks at the registered count, so a frame whose last result lands on the
      // final flush beat still spends one cycle here.
      ST_DRAIN: begin
        if ((res_cnt == frame_total) || timeout) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      o_done_intr <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_done_intr <= (state == ST_DONE);
    end
  end

  // Pixel output: one-cycle registered copy of the accepted beat, zeros while flushing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
    end else begin
      o_pix_valid <= accept || flush_beat;
      if (accept) o_pix_data <= s_data;
      else if (flush_beat) o_pix_data <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_total <= '0;
      flush_total <= '0;
      in_cnt      <= '0;
      flush_cnt   <= '0;
      res_cnt     <= '0;
    end else if (start_ok) begin
      frame_total <= CW'(i_width) * CW'(i_height);
      flush_total <= CW'(FLUSH_LINES) * CW'(i_width);
      in_cnt      <= '0;
      flush_cnt   <= '0;
      res_cnt     <= '0;
    end else begin
      if (accept) in_cnt <= in_cnt + ONE;
      if (flush_beat) flush_cnt <= flush_cnt + ONE;
      if (count_en && i_res_valid && (res_cnt != frame_total)) res_cnt <= res_cnt + ONE;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_cnt;
  logic          err;

  // Watchdog counts consecutive result-free DRAIN cycles.
  assign timeout = (state == ST_DRAIN) && !i_res_valid && (wd_cnt == T_LAST) &&
                   (res_cnt != frame_total);
  assign o_err   = err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if ((state != ST_DRAIN) || i_res_valid) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + TW'(1);
      if (start_ok) err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end
`else
  // Watchdog compiled out: timeout is constant false for any legal limit.
  assign timeout = (TIMEOUT_CYCLES < 0);
  assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// Directed bench for edge_frame_sequencer: frames, backpressure, zero geometry,
// mid-frame reset, ignored restart, and the watchdog when SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_edge_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] width;
  logic [10:0] height;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        ds_full;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        res_valid;
  logic        busy;
  logic        done_intr;
  logic        err;
  logic [2:0]  dbg_state;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int          pix_cnt = 0;
  int          done_cnt = 0;
  logic [7:0]  next_data = 8'h01;

  // clock / reset
  always #5 clk = ~clk;

  edge_frame_sequencer #(
    .W_BITS(11), .H_BITS(11), .FLUSH_LINES(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_width(width), .i_height(height),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .i_ds_full(ds_full),
    .o_pix_valid(pix_valid), .o_pix_data(pix_data), .i_res_valid(res_valid),
    .o_busy(busy), .o_done_intr(done_intr), .o_err(err), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every emitted pixel must match the head of exp_q
  always @(negedge clk) begin
    if (done_intr) done_cnt++;
    if (pix_valid) begin
      pix_cnt++;
      if (exp_q.size() == 0) check("pix_extra_valid", 32'(pix_valid), 32'd0);
      else check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
    end
  end

  // drivers
  task automatic start_frame(input logic [10:0] w, input logic [10:0] h);
    @(posedge clk); #1;
    start = 1'b1; width = w; height = h;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int stall_at, input int stall_len, input int restart_at);
    int   sent = 0;
    int   cyc = 0;
    logic acc;
    s_valid = 1'b1;
    s_data  = next_data;
    ds_full = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
    while (sent < n && cyc < 400) begin
      @(negedge clk);
      if (ds_full) check("stall_s_ready", 32'(s_ready), 32'd0);
      if (ds_full && cyc > stall_at) check("stall_pix_valid", 32'(pix_valid), 32'd0);
      acc = s_ready;
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(s_data);
        sent++;
        next_data = (next_data == 8'hff) ? 8'h01 : next_data + 8'h01;
        s_data = next_data;
      end
      cyc++;
      start = (cyc == restart_at);
      if (start) begin width = 11'd2; height = 11'd2; end
      ds_full = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
    end
    s_valid = 1'b0;
    ds_full = 1'b0;
    start   = 1'b0;
    check("feed_count", 32'(sent), 32'(n));
  endtask

  task automatic expect_flush(input int w);
    for (int i = 0; i < w; i++) exp_q.push_back(8'h00);
  endtask

  task automatic send_results(input int n);
    res_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1 res_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done_intr) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done_intr), 32'd0);
    end
  endtask

  task automatic frame_end(input string tag, input int exp_pix);
    @(negedge clk);
    check({tag, "_pix_total"}, 32'(pix_cnt), 32'(exp_pix));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    pix_cnt  = 0;
    done_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; width = '0; height = '0;
    s_valid = 1'b0; s_data = '0; ds_full = 1'b0; res_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_done", 32'(done_intr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: plain 4x4 frame
    start_frame(11'd4, 11'd4);
    check("t1_busy", 32'(busy), 32'd1);
    feed(16, -1, 0, -1);
    expect_flush(4);
    send_results(15);
    repeat (3) @(negedge clk);
    check("t1_busy_drain", 32'(busy), 32'd1);
    check("t1_no_early_done", 32'(done_cnt), 32'd0);
    send_results(1);
    wait_done("t1", 20);
    frame_end("t1", 20);

    // 2: five cycles of downstream backpressure mid-RUN
    start_frame(11'd4, 11'd4);
    feed(16, 6, 5, -1);
    expect_flush(4);
    send_results(16);
    wait_done("t2", 20);
    frame_end("t2", 20);

    // 3: zero width goes straight to DONE
    start_frame(11'd0, 11'd5);
    @(negedge clk);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_done_not_yet", 32'(done_intr), 32'd0);
    @(negedge clk);
    check("t3_busy_low", 32'(busy), 32'd0);
    check("t3_done", 32'(done_intr), 32'd1);
    @(negedge clk);
    check("t3_done_one_cycle", 32'(done_intr), 32'd0);
    frame_end("t3", 0);

    // 4: async reset after 7 beats, then a 3x3 frame
    start_frame(11'd4, 11'd4);
    feed(7, -1, 0, -1);
    #2 rst = 1'b1;
    #1;
    check("t4_async_busy", 32'(busy), 32'd0);
    check("t4_async_pix_valid", 32'(pix_valid), 32'd0);
    check("t4_async_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("t4_no_done", 32'(done_cnt), 32'd0);
    pix_cnt = 0;
    done_cnt = 0;
    start_frame(11'd3, 11'd3);
    feed(9, -1, 0, -1);
    expect_flush(3);
    send_results(9);
    wait_done("t4", 20);
    frame_end("t4", 12);

    // 6: start pulsed mid-RUN with new geometry is ignored
    start_frame(11'd4, 11'd4);
    feed(16, -1, 0, 5);
    expect_flush(4);
    send_results(16);
    wait_done("t6", 20);
    frame_end("t6", 20);

`ifdef SEQ_TIMEOUT_EN
    // 5: one result short -> watchdog ends the frame with o_err
    start_frame(11'd4, 11'd4);
    feed(16, -1, 0, -1);
    expect_flush(4);
    send_results(15);
    repeat (5) @(negedge clk);
    check("t5_no_early_done", 32'(done_cnt), 32'd0);
    check("t5_err_not_yet", 32'(err), 32'd0);
    wait_done("t5", 30);
    check("t5_err_set", 32'(err), 32'd1);
    frame_end("t5", 20);
    start_frame(11'd0, 11'd1);
    @(negedge clk);
    check("t5_err_cleared", 32'(err), 32'd0);
    wait_done("t5b", 10);
    frame_end("t5b", 0);
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
